instr_dispatch: RTL and testbench

INSTR_DISPATCH -- requirements
Module: instr_dispatch

---
 rtl/instr_dispatch_pkg.sv | 35 +++
 rtl/instr_dispatch_pc_counter.sv | 34 +++
 rtl/instr_dispatch.sv | 110 +++++++++++
 tb/tb_instr_dispatch.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_dispatch_pkg.sv
// ============================================================================
// Module : instr_dispatch_pkg
// Brief  : Opcodes, dispatcher state encoding and timeout limit.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package instr_dispatch_pkg;

  localparam logic [3:0] OPC_NOP    = 4'b0000;
  localparam logic [3:0] OPC_ALUI_A = 4'b0001;
  localparam logic [3:0] OPC_ALUI_B = 4'b0010;
  localparam logic [3:0] OPC_HALT   = 4'b1111;

  localparam int unsigned CNT_W   = 5;
  localparam logic [4:0]  TIMEOUT = 5'd31;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_EXEC  = 3'd4,
    ST_GAP   = 3'd5,
    ST_HALT  = 3'd6
  } state_e;

  function automatic logic [3:0] opcode_of(input logic [15:0] word);
    return word[15:12];
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_dispatch_pc_counter.sv
// ============================================================================
// Module : pc_counter
// Brief  : Program counter with increment and natural wrap-around.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module pc_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] pc
);

  logic [WIDTH-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (inc) pc_d = pc_q + WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_q <= '0;
    else      pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

`default_nettype wire

// File: rtl/instr_dispatch.sv
// ============================================================================
// Module : instr_dispatch
// Brief  : Fetches instruction words and broadcasts them to executor FSMs.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module instr_dispatch
  import instr_dispatch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [7:0]  mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_data,
  input  logic        mem_valid,
  output logic [15:0] instr,
  input  logic        pc_inc,
  input  logic        exec_done,
  output logic [7:0]  pc,
  output logic        busy,
  output logic        halted,
  output logic        err_timeout
);

  state_e           state_q, state_d;
  logic [15:0]      ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             pc_inc_en;

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    pc_inc_en = 1'b0;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT: begin
        if (mem_valid) begin
          ir_d    = mem_data;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        case (opcode_of(ir_q))
          OPC_NOP: begin
            pc_inc_en = 1'b1;
            state_d   = ST_GAP;
          end
          OPC_HALT: state_d = ST_HALT;
          default: begin
            cnt_d   = '0;
            state_d = ST_EXEC;
          end
        endcase
      end
      ST_EXEC: begin
        cnt_d     = cnt_q + 5'd1;
        pc_inc_en = pc_inc;
        // exec_done on the last allowed cycle still completes normally
        if (exec_done) begin
          state_d = ST_GAP;
        end else if (cnt_q == TIMEOUT - 5'd1) begin
          err_d   = 1'b1;
          state_d = ST_HALT;
        end
      end
      ST_GAP:  state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ir_q    <= 16'h0000;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  pc_counter #(.WIDTH(8)) u_pc (
    .clk (clk),
    .rst (rst),
    .inc (pc_inc_en),
    .pc  (pc)
  );

  // Outputs decode straight from the state flop so reset clears them at once
  assign instr       = (state_q == ST_EXEC) ? ir_q : 16'h0000;
  assign mem_rd      = (state_q == ST_FETCH);
  assign mem_addr    = pc;
  assign busy        = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign halted      = (state_q == ST_HALT);
  assign err_timeout = err_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_dispatch.sv
// ============================================================================
// Module : tb_instr_dispatch
// Brief  : Randomised self-checking bench with a transaction-level model.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_instr_dispatch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        mem_valid = 1'b0;
  logic        pc_inc = 1'b0;
  logic        exec_done = 1'b0;
  logic [15:0] mem_data = 16'h0;
  logic [7:0]  mem_addr;
  logic        mem_rd;
  logic [15:0] instr;
  logic [7:0]  pc;
  logic        busy;
  logic        halted;
  logic        err_timeout;

  always #5 clk = ~clk;

  instr_dispatch dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .mem_valid   (mem_valid),
    .instr       (instr),
    .pc_inc      (pc_inc),
    .exec_done   (exec_done),
    .pc          (pc),
    .busy        (busy),
    .halted      (halted),
    .err_timeout (err_timeout)
  );

  int          total = 0;
  int          bad = 0;
  logic [15:0] mem [256];
  logic [7:0]  m_pc = 8'h00;
  bit          m_halted = 1'b0;
  bit          m_err = 1'b0;
  bit          noise = 1'b0;

  task automatic step();
    @(negedge clk);
  endtask

  // Inputs the dispatcher must ignore in the current state
  task automatic set_noise(input bit allow_valid);
    start     = noise ? 1'($urandom) : 1'b0;
    pc_inc    = noise ? 1'($urandom) : 1'b0;
    exec_done = noise ? 1'($urandom) : 1'b0;
    mem_valid = (noise && allow_valid) ? 1'($urandom) : 1'b0;
    mem_data  = 16'($urandom);
  endtask

  task automatic do_reset();
    step();
    #2 rst = 1'b0;
    start = 0; pc_inc = 0; exec_done = 0; mem_valid = 0;
    step();
    rst = 1'b1;
    m_pc = 8'h00; m_halted = 1'b0; m_err = 1'b0;
  endtask

  task automatic kick();
    step();
    total++;
    if ({busy, halted, mem_rd, instr, pc} !== {1'b0, 1'b0, 1'b0, 16'h0, m_pc}) begin
      bad++;
      $display("FAIL idle: busy=%b halted=%b rd=%b instr=%h pc=%h, want 0 0 0 0000 %h",
               busy, halted, mem_rd, instr, pc, m_pc);
    end
    start = 1'b1;
  endtask

  // One fetch/issue/execute transaction, entered one cycle before FETCH
  task automatic do_instr(input int delay, input int done_at,
                          input logic [31:0] inc_mask, input int rst_at);
    logic [15:0] w;
    bit          done;
    done = 1'b0;
    w = mem[m_pc];
    step();
    set_noise(1'b1);
    total++;
    if ({mem_rd, mem_addr, busy, instr} !== {1'b1, m_pc, 1'b1, 16'h0}) begin
      bad++;
      $display("FAIL fetch: rd=%b addr=%h busy=%b instr=%h, want 1 %h 1 0000",
               mem_rd, mem_addr, busy, instr, m_pc);
    end
    for (int i = 0; i <= delay; i++) begin
      step();
      set_noise(1'b0);
      mem_valid = (i == delay);
      if (i == delay) mem_data = w;
      total++;
      if ({mem_rd, busy, halted, instr} !== {1'b0, 1'b1, 1'b0, 16'h0}) begin
        bad++;
        $display("FAIL wait: rd=%b busy=%b halted=%b instr=%h, want 0 1 0 0000",
                 mem_rd, busy, halted, instr);
      end
    end
    step();
    set_noise(1'b1);
    total++;
    if ({mem_rd, busy, instr, pc} !== {1'b0, 1'b1, 16'h0, m_pc}) begin
      bad++;
      $display("FAIL issue: rd=%b busy=%b instr=%h pc=%h, want 0 1 0000 %h",
               mem_rd, busy, instr, pc, m_pc);
    end
    if (w[15:12] == 4'h0) begin
      m_pc = m_pc + 8'd1;
      step();
      set_noise(1'b1);
      total++;
      if ({busy, instr, pc} !== {1'b1, 16'h0, m_pc}) begin
        bad++;
        $display("FAIL nop_gap: busy=%b instr=%h pc=%h, want 1 0000 %h", busy, instr, pc, m_pc);
      end
    end else if (w[15:12] == 4'hF) begin
      step();
      set_noise(1'b1);
      m_halted = 1'b1;
      total++;
      if ({halted, busy, mem_rd, instr, pc} !== {1'b1, 1'b0, 1'b0, 16'h0, m_pc}) begin
        bad++;
        $display("FAIL halt: halted=%b busy=%b rd=%b instr=%h pc=%h, want 1 0 0 0000 %h",
                 halted, busy, mem_rd, instr, pc, m_pc);
      end
    end else begin
      for (int k = 1; k <= 31; k++) begin
        step();
        total++;
        if ({instr, pc, busy} !== {w, m_pc, 1'b1}) begin
          bad++;
          $display("FAIL exec[%0d]: instr=%h pc=%h busy=%b, want %h %h 1",
                   k, instr, pc, busy, w, m_pc);
        end
        pc_inc    = inc_mask[k-1];
        exec_done = (k == done_at);
        start     = noise ? 1'($urandom) : 1'b0;
        mem_valid = noise ? 1'($urandom) : 1'b0;
        if (k == rst_at) begin
          #3 rst = 1'b0;
          #1;
          total++;
          if ({instr, mem_rd, busy, halted, pc} !== {16'h0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            bad++;
            $display("FAIL async_rst: instr=%h rd=%b busy=%b halted=%b pc=%h, want 0000 0 0 0 00",
                     instr, mem_rd, busy, halted, pc);
          end
          step();
          total++;
          if ({pc, busy, instr} !== {8'h00, 1'b0, 16'h0}) begin
            bad++;
            $display("FAIL rst_hold: pc=%h busy=%b instr=%h, want 00 0 0000", pc, busy, instr);
          end
          start = 0; pc_inc = 0; exec_done = 0; mem_valid = 0;
          rst = 1'b1;
          m_pc = 8'h00; m_halted = 1'b0; m_err = 1'b0;
          return;
        end
        if (pc_inc) m_pc = m_pc + 8'd1;
        if (exec_done) begin
          done = 1'b1;
          break;
        end
      end
      step();
      set_noise(1'b1);
      if (done) begin
        total++;
        if ({busy, instr, pc, halted} !== {1'b1, 16'h0, m_pc, 1'b0}) begin
          bad++;
          $display("FAIL gap: busy=%b instr=%h pc=%h halted=%b, want 1 0000 %h 0",
                   busy, instr, pc, halted, m_pc);
        end
      end else begin
        m_halted = 1'b1;
        m_err    = 1'b1;
        total++;
        if ({halted, err_timeout, busy, instr, mem_rd, pc} !==
            {1'b1, 1'b1, 1'b0, 16'h0, 1'b0, m_pc}) begin
          bad++;
          $display("FAIL timeout: halted=%b err=%b busy=%b instr=%h rd=%b pc=%h, want 1 1 0 0000 0 %h",
                   halted, err_timeout, busy, instr, mem_rd, pc, m_pc);
        end
      end
    end
  endtask

  task automatic check_halt_hold();
    for (int i = 0; i < 6; i++) begin
      start = 1'($urandom); pc_inc = 1'($urandom);
      exec_done = 1'($urandom); mem_valid = 1'($urandom);
      step();
      total++;
      if ({halted, busy, mem_rd, instr, pc, err_timeout} !==
          {1'b1, 1'b0, 1'b0, 16'h0, m_pc, m_err}) begin
        bad++;
        $display("FAIL halt_hold: halted=%b busy=%b rd=%b instr=%h pc=%h err=%b, want 1 0 0 0000 %h %b",
                 halted, busy, mem_rd, instr, pc, err_timeout, m_pc, m_err);
      end
    end
    start = 0; pc_inc = 0; exec_done = 0; mem_valid = 0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    total++;
    if ({pc, instr, mem_rd, busy, halted, err_timeout} !== {8'h00, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset: pc=%h instr=%h rd=%b busy=%b halted=%b err=%b, want all zero",
               pc, instr, mem_rd, busy, halted, err_timeout);
    end
    step();
    step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc_inc = 1'b1; exec_done = 1'b1; mem_valid = 1'b1;
      step();
      total++;
      if ({busy, mem_rd, pc} !== {1'b0, 1'b0, 8'h00}) begin
        bad++;
        $display("FAIL idle_hold: busy=%b rd=%b pc=%h, want 0 0 00", busy, mem_rd, pc);
      end
    end
    pc_inc = 0; exec_done = 0; mem_valid = 0;
  endtask

  task automatic test_basic();
    do_reset();
    mem[0] = 16'h1042; mem[1] = 16'hF000;
    kick();
    do_instr(1, 8, 32'h1, 0);
    do_instr(0, 0, 32'h0, 0);
    check_halt_hold();
  endtask

  task automatic test_nop_halt();
    do_reset();
    mem[0] = 16'h0000; mem[1] = 16'hF000;
    kick();
    do_instr(0, 0, 32'h0, 0);
    do_instr(1, 0, 32'h0, 0);
    check_halt_hold();
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 255; i++) mem[i] = 16'h0000;
    mem[255] = 16'h2005;
    kick();
    for (int i = 0; i < 255; i++) do_instr(int'($urandom_range(0, 2)), 0, 32'h0, 0);
    mem[0] = 16'hF000;
    do_instr(0, 2, 32'h1, 0);
    total++;
    if (pc !== 8'h00) begin
      bad++;
      $display("FAIL wrap: pc=%h, want 00", pc);
    end
    do_instr(0, 0, 32'h0, 0);
    check_halt_hold();
  endtask

  task automatic test_timeout();
    do_reset();
    mem[0] = 16'h1003;
    kick();
    do_instr(2, 0, $urandom & $urandom & $urandom, 0);
    check_halt_hold();
  endtask

  task automatic test_async_reset();
    do_reset();
    mem[0] = 16'h1042;
    kick();
    do_instr(0, 10, 32'hFF, 3);
    mem[0] = 16'hF000;
    kick();
    do_instr(1, 0, 32'h0, 0);
    check_halt_hold();
  endtask

  task automatic test_ignored();
    do_reset();
    noise = 1'b1;
    mem[0] = 16'h1042; mem[1] = 16'hF000;
    kick();
    do_instr(1, 8, 32'h1, 0);
    do_instr(2, 0, 32'h0, 0);
    noise = 1'b0;
    check_halt_hold();
  endtask

  task automatic test_back_to_back();
    logic [3:0] op;
    noise = 1'b1;
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int i = 0; i < 256; i++) begin
        op = 4'($urandom_range(0, 15));
        if (op == 4'hF && $urandom_range(0, 2) != 0) op = 4'h1;
        mem[i] = {op, 12'($urandom)};
      end
      kick();
      for (int n = 0; n < 50 && !m_halted; n++)
        do_instr(int'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 31)),
                 $urandom & $urandom & $urandom, 0);
      if (m_halted) check_halt_hold();
    end
    noise = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
    test_reset();
    test_basic();
    test_nop_halt();
    test_wrap();
    test_timeout();
    test_async_reset();
    test_ignored();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
